// File: rtl/gpr_pkg.sv
// Shared constants and types for the gpr write-back queue.
package gpr_pkg;

  localparam int unsigned GPR_AW = 5;
  localparam int unsigned GPR_DW = 32;

  // r0 is hardwired to zero, so writes to it are never queued
  localparam logic [GPR_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [GPR_AW-1:0] addr;
    logic [GPR_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Generic synchronous FIFO with occupancy count, flush, and an
// age-ordered view of all entries (index 0 = oldest) for compare logic.
module gpr_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [WIDTH-1:0]           entries [DEPTH],
  output logic [DEPTH-1:0]           live
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy update; flush wins over any push/pop that cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Age-ordered view: slot k is the k-th oldest entry
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PW'(k)];
      live[k]    = (CW'(k) < count);
    end
  end

endmodule

// File: rtl/gpr_wb_queue.sv
// Producer side of the gpr write port: buffers register writes, drains one
// per cycle onto regwrite/m1out/m2out, and flags RAW hazards on rs/rt.
// Optional macro GPR_WBQ_FWD_EN adds rs_fwd/rt_fwd forwarding data outputs.
module gpr_wb_queue
  import gpr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = GPR_AW,
  parameter int unsigned DW    = GPR_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  input  logic                   flush,
  input  logic [AW-1:0]          rs,
  input  logic [AW-1:0]          rt,
  output logic                   rs_pending,
  output logic                   rt_pending,
  output logic                   regwrite,
  output logic [AW-1:0]          m1out,
  output logic [DW-1:0]          m2out,
`ifdef GPR_WBQ_FWD_EN
  output logic [DW-1:0]          rs_fwd,
  output logic [DW-1:0]          rt_fwd,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned EW = AW + DW;

  logic          push;
  logic          full;
  logic [EW-1:0] head;
  logic [EW-1:0] entries [DEPTH];
  logic [DEPTH-1:0] live;

  // Writes to r0 complete the handshake but are dropped here
  assign in_ready = !full;
  assign push     = in_valid && in_ready && (in_addr != AW'(REG_ZERO));

  gpr_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (count != '0),
    .flush   (flush),
    .wdata   ({in_addr, in_data}),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .entries (entries),
    .live    (live)
  );

  // Issue register: load head each cycle the queue is non-empty; a flush
  // discards the head too, but the entry already here still completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite <= 1'b0;
      m1out    <= '0;
      m2out    <= '0;
    end else if (!flush && (count != '0)) begin
      regwrite <= 1'b1;
      m1out    <= head[EW-1:DW];
      m2out    <= head[DW-1:0];
    end else begin
      regwrite <= 1'b0;
    end
  end

  // RAW hazard detection against queued entries and the issuing entry
  always_comb begin
    rs_pending = regwrite && (m1out == rs);
    rt_pending = regwrite && (m1out == rt);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (live[k] && (entries[k][EW-1:DW] == rs)) rs_pending = 1'b1;
      if (live[k] && (entries[k][EW-1:DW] == rt)) rt_pending = 1'b1;
    end
    if (rs == AW'(REG_ZERO)) rs_pending = 1'b0;
    if (rt == AW'(REG_ZERO)) rt_pending = 1'b0;
  end

`ifdef GPR_WBQ_FWD_EN
  // Forward data: issue regs lowest priority, then FIFO oldest to youngest
  // so the youngest matching entry overrides everything older
  always_comb begin
    rs_fwd = '0;
    rt_fwd = '0;
    if (regwrite && (m1out == rs)) rs_fwd = m2out;
    if (regwrite && (m1out == rt)) rt_fwd = m2out;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (live[k] && (entries[k][EW-1:DW] == rs)) rs_fwd = entries[k][DW-1:0];
      if (live[k] && (entries[k][EW-1:DW] == rt)) rt_fwd = entries[k][DW-1:0];
    end
    if (rs == AW'(REG_ZERO)) rs_fwd = '0;
    if (rt == AW'(REG_ZERO)) rt_fwd = '0;
  end
`endif

endmodule
